// File: rtl/booth16_seq_mul_ctrl_if.sv
// Operand/product handshake bundle for booth16_seq_mul_ctrl.
// The master drives operands and product acceptance; the slave is the multiplier.
interface booth16_seq_mul_ctrl_if #(
   parameter int WIDTH = 8
);
   logic               op_valid;
   logic               op_ready;
   logic [WIDTH-1:0]   mcand;
   logic [WIDTH-1:0]   mplier;
   logic               prod_valid;
   logic               prod_ready;
   logic [2*WIDTH-1:0] prod;
   logic               busy;

   modport master (
      output op_valid, mcand, mplier, prod_ready,
      input  op_ready, prod_valid, prod, busy
   );

   modport slave (
      input  op_valid, mcand, mplier, prod_ready,
      output op_ready, prod_valid, prod, busy
   );
endinterface

// File: rtl/booth16_seq_mul_ctrl.sv
// Sequential radix-16 Booth multiplier: one 5-bit window per cycle, odd multiples precomputed.
// Optional early termination on a sign-uniform multiplier tail: define BOOTH_ZERO_SKIP_EN.
module booth16_seq_mul_ctrl #(
   parameter int WIDTH = 8
) (
   input logic                   clk,
   input logic                   rst,
   booth16_seq_mul_ctrl_if.slave bus
);
   localparam int DIGITS = WIDTH / 4;
   localparam int PW     = 2 * WIDTH;
   localparam int KW     = $clog2(DIGITS);
   localparam int SW     = $clog2(PW);

   typedef enum logic [1:0] {IDLE, PRE, ITER, DONE} state_t;

   state_t          state;
   state_t          state_n;
   logic            accept;
   logic            tail_uniform;

   logic [PW-1:0]    a_q;
   logic [WIDTH-1:0] b_q;
   logic [PW-1:0]    m3;
   logic [PW-1:0]    m5;
   logic [PW-1:0]    m7;
   logic [PW-1:0]    acc;
   logic [KW-1:0]    k;

   logic [WIDTH:0]   b_ext;
   logic [SW-1:0]    base;
   logic [4:0]       win;
   int               dig;
   int unsigned      mag;
   logic             neg;
   logic [PW-1:0]    m;
   logic [1:0]       s;
   logic [SW-1:0]    shamt;
   logic [PW-1:0]    term;

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_n;
   end

   always_comb begin
      state_n        = state;
      accept         = 1'b0;
      bus.op_ready   = (state == IDLE);
      bus.prod_valid = (state == DONE);
      bus.busy       = (state == PRE) || (state == ITER);
      bus.prod       = acc;
      case (state)
         IDLE: if (bus.op_valid) begin
            accept  = 1'b1;
            state_n = PRE;
         end
         PRE:  state_n = ITER;
         ITER: if (k == KW'(DIGITS - 1) || tail_uniform) state_n = DONE;
         DONE: if (bus.prod_ready) state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   // Booth window for digit k; B[-1] is the appended zero at b_ext[0].
   always_comb begin
      b_ext = {b_q, 1'b0};
      base  = SW'({k, 2'b00});
      win   = 5'(b_ext >> base);
      dig   = -8 * int'(win[4]) + 4 * int'(win[3]) + 2 * int'(win[2])
              + int'(win[1]) + int'(win[0]);
      neg   = (dig < 0);
      mag   = neg ? unsigned'(-dig) : unsigned'(dig);
      m     = '0;
      s     = 2'd0;
      case (mag)
         1: begin m = a_q; s = 2'd0; end
         2: begin m = a_q; s = 2'd1; end
         3: begin m = m3;  s = 2'd0; end
         4: begin m = a_q; s = 2'd2; end
         5: begin m = m5;  s = 2'd0; end
         6: begin m = m3;  s = 2'd1; end
         7: begin m = m7;  s = 2'd0; end
         8: begin m = a_q; s = 2'd3; end
         default: begin m = '0; s = 2'd0; end
      endcase
      shamt = base + SW'(s);
      term  = (neg ? -m : m) << shamt;
   end

`ifdef BOOTH_ZERO_SKIP_EN
   logic signed [WIDTH-1:0] tail;

   // Bits B[W-1:4k+3] all equal means every remaining window decodes to zero.
   always_comb begin
      tail         = $signed(b_q) >>> (base + SW'(3));
      tail_uniform = (tail == '0) || (tail == '1);
   end
`else
   always_comb tail_uniform = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         a_q <= '0;
         b_q <= '0;
         m3  <= '0;
         m5  <= '0;
         m7  <= '0;
         acc <= '0;
         k   <= '0;
      end else begin
         case (state)
            IDLE: if (accept) begin
               a_q <= {{WIDTH{bus.mcand[WIDTH-1]}}, bus.mcand};
               b_q <= bus.mplier;
               acc <= '0;
               k   <= '0;
            end
            PRE: begin
               m3 <= a_q + (a_q << 1);
               m5 <= a_q + (a_q << 2);
               m7 <= (a_q << 3) - a_q;
            end
            ITER: begin
               acc <= acc + term;
               k   <= k + KW'(1);
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_booth16_seq_mul_ctrl.sv
// Self-checking bench: directed corner cases, backpressure, mid-op reset, random sweep
// against a plain-arithmetic product and latency reference.
module tb_booth16_seq_mul_ctrl;
   localparam int W = 8;
   localparam int D = W / 4;

   logic clk;
   logic rst;
   int   checks;
   int   errors;
   int   n;

   booth16_seq_mul_ctrl_if #(.WIDTH(W)) bus ();

   booth16_seq_mul_ctrl #(.WIDTH(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   function automatic logic [2*W-1:0] ref_prod(input logic [W-1:0] a, input logic [W-1:0] b);
      logic signed [2*W-1:0] sa;
      logic signed [2*W-1:0] sb;
      sa = $signed(a);
      sb = $signed(b);
      return sa * sb;
   endfunction

   // Edges from acceptance until the product is presented.
   function automatic int ref_lat(input logic [W-1:0] b);
`ifdef BOOTH_ZERO_SKIP_EN
      bit all0;
      bit all1;
      for (int kk = 0; kk < D - 1; kk++) begin
         all0 = 1'b1;
         all1 = 1'b1;
         for (int i = 4 * (kk + 1) - 1; i < W; i++) begin
            if (b[i]) all0 = 1'b0;
            else      all1 = 1'b0;
         end
         if (all0 || all1) return 2 + kk;
      end
      return 1 + D;
`else
      return (b === b) ? 1 + D : 0;
`endif
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_valid(output int cnt);
      cnt = 0;
      while (bus.prod_valid !== 1'b1 && cnt < 40) begin
         @(negedge clk);
         cnt++;
      end
   endtask

   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b);
      int lat;
      @(negedge clk);
      chk("ready_before", 32'(bus.op_ready), 1);
      bus.op_valid   = 1'b1;
      bus.mcand      = a;
      bus.mplier     = b;
      bus.prod_ready = 1'b1;
      @(negedge clk);
      bus.op_valid = 1'b0;
      wait_valid(lat);
      chk("latency", 32'(lat), 32'(ref_lat(b)));
      chk("prod", 32'(bus.prod), 32'(ref_prod(a, b)));
      @(negedge clk);
      chk("ready_after", 32'(bus.op_ready), 1);
      chk("valid_after", 32'(bus.prod_valid), 0);
   endtask

   initial begin
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      checks         = 0;
      errors         = 0;
      clk            = 1'b0;
      rst            = 1'b1;
      bus.op_valid   = 1'b0;
      bus.mcand      = '0;
      bus.mplier     = '0;
      bus.prod_ready = 1'b0;

      repeat (2) @(negedge clk);
      chk("rst_ready", 32'(bus.op_ready), 1);
      chk("rst_valid", 32'(bus.prod_valid), 0);
      chk("rst_busy", 32'(bus.busy), 0);
      chk("rst_prod", 32'(bus.prod), 0);
      rst = 1'b0;

      run_op(8'h07, 8'h13);
      chk("prod_7x19", 32'(bus.prod), 32'h0085);
      run_op(8'h80, 8'h80);
      chk("prod_m128sq", 32'(bus.prod), 32'h4000);
      run_op(8'h7F, 8'h80);
      chk("prod_127xm128", 32'(bus.prod), 32'hC080);
      run_op(8'hFD, 8'h05);
      chk("prod_m3x5", 32'(bus.prod), 32'hFFF1);
      run_op(8'h80, 8'h7F);
      run_op(8'h00, 8'h00);
      run_op(8'hFF, 8'hFF);
      run_op(8'h80, 8'h01);
      run_op(8'h01, 8'h80);
      run_op(8'h05, 8'h0F);
      run_op(8'h05, 8'hF0);

      // Backpressure: hold product while new operands are offered.
      @(negedge clk);
      bus.op_valid   = 1'b1;
      bus.mcand      = 8'h35;
      bus.mplier     = 8'hC7;
      bus.prod_ready = 1'b0;
      @(negedge clk);
      bus.op_valid = 1'b0;
      wait_valid(n);
      chk("bp_valid", 32'(bus.prod_valid), 1);
      bus.op_valid = 1'b1;
      bus.mcand    = 8'h9A;
      bus.mplier   = 8'h2B;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk("bp_hold_valid", 32'(bus.prod_valid), 1);
         chk("bp_hold_prod", 32'(bus.prod), 32'(ref_prod(8'h35, 8'hC7)));
         chk("bp_hold_ready", 32'(bus.op_ready), 0);
      end
      bus.prod_ready = 1'b1;
      @(negedge clk);
      chk("bp_rel_valid", 32'(bus.prod_valid), 0);
      chk("bp_rel_ready", 32'(bus.op_ready), 1);
      @(negedge clk);
      bus.op_valid = 1'b0;
      chk("bp_accept_busy", 32'(bus.busy), 1);
      wait_valid(n);
      chk("bp_new_prod", 32'(bus.prod), 32'(ref_prod(8'h9A, 8'h2B)));
      @(negedge clk);

      // Reset while iterating digit 0.
      @(negedge clk);
      bus.op_valid = 1'b1;
      bus.mcand    = 8'h6D;
      bus.mplier   = 8'hA5;
      @(negedge clk);
      bus.op_valid = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("mid_rst_ready", 32'(bus.op_ready), 1);
      chk("mid_rst_valid", 32'(bus.prod_valid), 0);
      chk("mid_rst_busy", 32'(bus.busy), 0);
      chk("mid_rst_prod", 32'(bus.prod), 0);
      run_op(8'h6D, 8'hA5);

      for (int r = 0; r < 1500; r++) begin
         ra = W'($urandom);
         rb = W'($urandom);
         run_op(ra, rb);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
